// File: rtl/lfsr_22_chk.sv
// Receive-side checker for the 22-bit LFSR 2-bit symbol stream.
// Self-synchronises, locks, then flywheels and counts bit errors.
module lfsr_22_chk #(
  parameter int LOCK_CNT = 64,
  parameter int LOSS_CNT = 8,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sym_en,
  input  logic [1:0]       sym_in,
  input  logic             clr_cnt,
  output logic             locked,
  output logic             sym_err,
  output logic [CNT_W-1:0] bit_err_cnt,
  output logic [CNT_W-1:0] sym_cnt,
  output logic [1:0]       state
);

  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam int RW = $clog2(LOSS_CNT + 1);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } st_t;

  st_t              r_st, w_st;
  logic [21:0]      r_r, w_r;
  logic [4:0]       r_fill, w_fill;
  logic [GW-1:0]    r_good, w_good;
  logic [RW-1:0]    r_run, w_run;
  logic [CNT_W-1:0] r_berr, w_berr;
  logic [CNT_W-1:0] r_scnt, w_scnt;
  logic             r_lock, w_lock;
  logic             r_serr, w_serr;

  logic             w_exp_hi, w_exp_lo;
  logic [1:0]       w_mis, w_nerr;
  logic             w_good_sym;
  logic [GW-1:0]    w_good_inc;
  logic [RW-1:0]    w_run_inc;
  logic [CNT_W:0]   w_bsum;
  logic [CNT_W-1:0] w_bsat, w_ssat;

  // Predict the next two stream bits from the recurrence b[n+22]=b[n]^b[n+1]
  assign w_exp_hi   = r_r[21] ^ r_r[20];
  assign w_exp_lo   = r_r[20] ^ r_r[19];
  assign w_mis      = sym_in ^ {w_exp_hi, w_exp_lo};
  assign w_nerr     = {1'b0, w_mis[1]} + {1'b0, w_mis[0]};
  assign w_good_sym = (w_mis == 2'b00) && (|r_r);
  assign w_good_inc = r_good + 1'b1;
  assign w_run_inc  = r_run + 1'b1;

  assign w_bsum = {1'b0, r_berr} + {{(CNT_W-1){1'b0}}, w_nerr};
  assign w_bsat = w_bsum[CNT_W] ? {CNT_W{1'b1}} : w_bsum[CNT_W-1:0];
  assign w_ssat = (&r_scnt) ? r_scnt : r_scnt + 1'b1;

  always_comb begin
    w_st   = r_st;
    w_r    = r_r;
    w_fill = r_fill;
    w_good = r_good;
    w_run  = r_run;
    w_berr = r_berr;
    w_scnt = r_scnt;
    w_serr = 1'b0;
    if (sym_en) begin
      unique case (r_st)
        SEARCH: begin
          w_r    = {r_r[20:0], sym_in[1]};
          w_fill = r_fill + 5'd1;
          if (r_fill == 5'd21) begin
            w_st   = TRACK;
            w_good = '0;
          end
        end
        TRACK: begin
          w_r = {r_r[20:0], sym_in[1]};
          if (w_good_sym) begin
            w_good = w_good_inc;
            if (w_good_inc == GW'(LOCK_CNT)) begin
              w_st  = LOCKED;
              w_run = '0;
            end
          end else begin
            w_good = '0;
          end
        end
        LOCKED: begin
          // Flywheel: feed back our own prediction, never the channel
          w_r    = {r_r[20:0], w_exp_hi};
          w_scnt = w_ssat;
          if (|w_mis) begin
            w_berr = w_bsat;
            w_serr = 1'b1;
            w_run  = w_run_inc;
            if (w_run_inc == RW'(LOSS_CNT)) begin
              w_st   = SEARCH;
              w_fill = '0;
            end
          end else begin
            w_run = '0;
          end
        end
        default: w_st = SEARCH;
      endcase
    end
    if (clr_cnt) begin
      w_berr = '0;
      w_scnt = '0;
    end
    w_lock = (w_st == LOCKED);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_st   <= SEARCH;
      r_r    <= '0;
      r_fill <= '0;
      r_good <= '0;
      r_run  <= '0;
      r_berr <= '0;
      r_scnt <= '0;
      r_lock <= 1'b0;
      r_serr <= 1'b0;
    end else begin
      r_st   <= w_st;
      r_r    <= w_r;
      r_fill <= w_fill;
      r_good <= w_good;
      r_run  <= w_run;
      r_berr <= w_berr;
      r_scnt <= w_scnt;
      r_lock <= w_lock;
      r_serr <= w_serr;
    end
  end

  assign locked      = r_lock;
  assign sym_err     = r_serr;
  assign bit_err_cnt = r_berr;
  assign sym_cnt     = r_scnt;
  assign state       = r_st;

endmodule

// File: tb/tb_lfsr_22_chk.sv
// Scoreboard bench for lfsr_22_chk: default instance plus a
// CNT_W=4 / LOSS_CNT=16 instance on the same symbol stream.
module tb_lfsr_22_chk;

  logic       clk = 1'b0;
  logic       rst_n, sym_en, clr_cnt;
  logic [1:0] sym_in;

  logic        lk0, se0, lk1, se1;
  logic [31:0] be0, sc0;
  logic [3:0]  be1, sc1;
  logic [1:0]  st0, st1;

  always #5 clk = ~clk;

  lfsr_22_chk u0 (
    .clk(clk), .reset(rst_n), .sym_en(sym_en),
    .sym_in(sym_in), .clr_cnt(clr_cnt), .locked(lk0),
    .sym_err(se0), .bit_err_cnt(be0), .sym_cnt(sc0),
    .state(st0)
  );

  lfsr_22_chk #(.LOCK_CNT(64), .LOSS_CNT(16), .CNT_W(4)) u1 (
    .clk(clk), .reset(rst_n), .sym_en(sym_en),
    .sym_in(sym_in), .clr_cnt(clr_cnt), .locked(lk1),
    .sym_err(se1), .bit_err_cnt(be1), .sym_cnt(sc1),
    .state(st1)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(string nm, longint act, longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 30)
        $display("FAIL %s act=%0d exp=%0d", nm, act, exp);
    end
  endtask

  // Reference model: stream history indexed by symbol number
  int     P_LOSS [2] = '{8, 16};
  int     P_W    [2] = '{32, 4};
  int     m_st   [2];
  int     m_fill [2];
  int     m_good [2];
  int     m_run  [2];
  longint m_berr [2];
  longint m_scnt [2];
  bit     m_serr [2];
  int     m_n    [2];
  bit     m_b    [2][22];

  typedef struct {
    bit     lk;
    bit     se;
    longint be;
    longint sc;
    int     st;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  task automatic mstep(int k, bit en, bit [1:0] s, bit clr, bit rst);
    bit     o0, o1, o2, hi, lo, nz, nb;
    int     nerr;
    longint mx;
    mx = (longint'(1) << P_W[k]) - 1;
    if (!rst) begin
      m_st[k] = 0; m_fill[k] = 0; m_good[k] = 0; m_run[k] = 0;
      m_berr[k] = 0; m_scnt[k] = 0; m_serr[k] = 0; m_n[k] = 0;
      for (int i = 0; i < 22; i++) m_b[k][i] = 1'b0;
      return;
    end
    m_serr[k] = 1'b0;
    if (en) begin
      o0 = m_b[k][m_n[k] % 22];
      o1 = m_b[k][(m_n[k] + 1) % 22];
      o2 = m_b[k][(m_n[k] + 2) % 22];
      hi = o0 ^ o1;
      lo = o1 ^ o2;
      nerr = int'(s[1] != hi) + int'(s[0] != lo);
      nz = 1'b0;
      for (int i = 0; i < 22; i++) nz |= m_b[k][i];
      nb = (m_st[k] == 2) ? hi : s[1];
      case (m_st[k])
        0: begin
          m_fill[k]++;
          if (m_fill[k] == 22) begin m_st[k] = 1; m_good[k] = 0; end
        end
        1: begin
          m_good[k] = (nerr == 0 && nz) ? m_good[k] + 1 : 0;
          if (m_good[k] == 64) begin m_st[k] = 2; m_run[k] = 0; end
        end
        default: begin
          m_scnt[k] = (m_scnt[k] + 1 > mx) ? mx : m_scnt[k] + 1;
          if (nerr > 0) begin
            m_berr[k] = (m_berr[k] + nerr > mx) ? mx : m_berr[k] + nerr;
            m_serr[k] = 1'b1;
            m_run[k]++;
            if (m_run[k] == P_LOSS[k]) begin m_st[k] = 0; m_fill[k] = 0; end
          end else begin
            m_run[k] = 0;
          end
        end
      endcase
      m_b[k][m_n[k] % 22] = nb;
      m_n[k]++;
    end
    if (clr) begin m_berr[k] = 0; m_scnt[k] = 0; end
  endtask

  function automatic exp_t mexp(int k);
    exp_t e;
    e.lk = (m_st[k] == 2);
    e.se = m_serr[k];
    e.be = m_berr[k];
    e.sc = m_scnt[k];
    e.st = m_st[k];
    return e;
  endfunction

  // Monitor: every clock the DUT presents a registered result
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q0.size() > 0) begin
      e = q0.pop_front();
      chk("u0_locked", lk0, e.lk);
      chk("u0_sym_err", se0, e.se);
      chk("u0_bit_err", be0, e.be);
      chk("u0_sym_cnt", sc0, e.sc);
      chk("u0_state", st0, e.st);
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      chk("u1_locked", lk1, e.lk);
      chk("u1_sym_err", se1, e.se);
      chk("u1_bit_err", be1, e.be);
      chk("u1_sym_cnt", sc1, e.sc);
      chk("u1_state", st1, e.st);
    end
  end

  logic [21:0] g;
  bit          force_zero = 1'b0;

  // Drive one cycle at a negedge; returns at the next negedge
  task automatic cyc(bit en, bit [1:0] err, bit clr, bit rst);
    bit [1:0] s;
    if (force_zero)
      s = 2'b00;
    else if (en)
      s = {g[21], g[20]} ^ err;
    else
      s = 2'($urandom_range(0, 3));
    rst_n   = rst;
    sym_en  = en;
    sym_in  = s;
    clr_cnt = clr;
    if (en && rst) g = {g[20:0], g[21] ^ g[20]};
    mstep(0, en, s, clr, rst);
    mstep(1, en, s, clr, rst);
    q0.push_back(mexp(0));
    q1.push_back(mexp(1));
    @(negedge clk);
  endtask

  task automatic clean(int n);
    repeat (n) cyc(1'b1, 2'b00, 1'b0, 1'b1);
  endtask

  initial begin
    bit seen2;
    bit [1:0] e;
    rst_n = 1'b0; sym_en = 1'b0; sym_in = 2'b00; clr_cnt = 1'b0;
    g = 22'h000001;
    @(negedge clk);
    cyc(1'b0, 2'b00, 1'b0, 1'b0);
    cyc(1'b1, 2'b00, 1'b1, 1'b0);
    chk("rst_locked", lk0, 0);
    chk("rst_state", st0, 0);
    chk("rst_counts", be0 | sc0, 0);

    // Acquisition on a clean stream: lock after symbol 86
    clean(85);
    chk("pre_lock_locked", lk0, 0);
    chk("pre_lock_state", st0, 1);
    clean(1);
    chk("lock_86_locked", lk0, 1);
    chk("lock_86_state", st0, 2);
    chk("lock_86_u1", lk1, 1);
    clean(1000);
    chk("clean_sym_cnt", sc0, 1000);
    chk("clean_bit_err", be0, 0);
    chk("u1_sym_sat", sc1, 15);

    // Single flipped bit: no error multiplication
    cyc(1'b1, 2'b10, 1'b0, 1'b1);
    chk("single_sym_err", se0, 1);
    chk("single_bit_err", be0, 1);
    clean(100);
    chk("single_after_err", be0, 1);
    chk("single_after_lock", lk0, 1);

    // Eight double-bit errors: u0 drops lock, u1 saturates
    cyc(1'b1, 2'b00, 1'b1, 1'b1);
    repeat (7) cyc(1'b1, 2'b11, 1'b0, 1'b1);
    chk("loss7_locked", lk0, 1);
    cyc(1'b1, 2'b11, 1'b0, 1'b1);
    chk("loss8_locked", lk0, 0);
    chk("loss8_sym_err", se0, 1);
    chk("loss8_bit_err", be0, 16);
    chk("loss8_u1_sat", be1, 15);
    chk("loss8_u1_lock", lk1, 1);
    clean(85);
    chk("relock85", lk0, 0);
    clean(1);
    chk("relock86", lk0, 1);

    // u1: nine double errors saturate, then clear on an errored symbol
    cyc(1'b1, 2'b00, 1'b1, 1'b1);
    repeat (9) cyc(1'b1, 2'b11, 1'b0, 1'b1);
    chk("sat9_u1_err", be1, 15);
    chk("sat9_u1_lock", lk1, 1);
    cyc(1'b1, 2'b11, 1'b1, 1'b1);
    chk("clr_err_u1", be1, 0);
    chk("clr_lock_u1", lk1, 1);
    clean(100);
    chk("relock_after_sat", lk0, 1);

    // Sparse strobes with occasional errors, then a reset pulse
    repeat (60) begin
      e = ($urandom_range(0, 7) == 0) ? 2'b01 : 2'b00;
      cyc(1'b1, e, 1'b0, 1'b1);
      repeat (3) cyc(1'b0, 2'b00, 1'b0, 1'b1);
    end
    chk("gaps_locked", lk0, 1);
    cyc(1'b1, 2'b00, 1'b0, 1'b0);
    chk("midrst_locked", lk0 | lk1, 0);
    chk("midrst_sym_err", se0 | se1, 0);
    chk("midrst_counts", be0 | sc0 | 32'(be1) | 32'(sc1), 0);
    chk("midrst_state", st0 | st1, 0);

    // Stuck-zero input never locks
    force_zero = 1'b1;
    seen2 = 1'b0;
    repeat (500) begin
      cyc(1'b1, 2'b00, 1'b0, 1'b1);
      if (st0 == 2'd2 || st1 == 2'd2) seen2 = 1'b1;
    end
    force_zero = 1'b0;
    chk("zero_never_locked", seen2, 0);
    chk("zero_locked", lk0, 0);
    chk("zero_counts", be0 | sc0, 0);

    // Random traffic: strobes, errors, bursts and clears
    cyc(1'b1, 2'b00, 1'b0, 1'b0);
    clean(90);
    repeat (3000) begin
      if ($urandom_range(0, 399) == 0) begin
        repeat (18) cyc(1'b1, 2'($urandom_range(1, 3)), 1'b0, 1'b1);
      end else begin
        e = ($urandom_range(0, 15) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
        cyc($urandom_range(0, 3) != 0, e, $urandom_range(0, 199) == 0, 1'b1);
      end
    end
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lfsr_22_chk.md
# lfsr_22_chk

Receive-side checker for the 2-bit symbol stream from the 22-bit maximal-length LFSR generator. It reconstructs the generator sequence from received symbols and declares lock after a run of error-free symbols. While locked it flywheels on its own prediction, flags errored symbols and keeps saturating bit-error and symbol counters. It sits at the far end of the symbol path, on the same clock and symbol enable as the generator, and gives the bench and the board a BER measurement point.

## Interface
- LOCK_CNT, 64: consecutive good symbols in TRACK needed to enter LOCKED.
- LOSS_CNT, 8: consecutive errored symbols in LOCKED that force SEARCH.
- CNT_W, 32: width of the error and symbol counters.
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- sym_en  in  1  symbol-valid strobe. All state advances only on cycles where it is high.
- sym_in  in  2  received symbol; sym_in[1] = gen state bit 21, sym_in[0] = gen state bit 20.
- clr_cnt  in  1  synchronous clear of bit_err_cnt and sym_cnt.
- locked  out  1  high in LOCKED.
- sym_err  out  1  one-cycle pulse for each errored symbol checked in LOCKED.
- bit_err_cnt  out  CNT_W  saturating count of errored bits while LOCKED.
- sym_cnt  out  CNT_W  saturating count of symbols checked while LOCKED.
- state  out  2  0 = SEARCH, 1 = TRACK, 2 = LOCKED.

## Operation
- Generator model:
  - s' = {s[20:0], s[21]^s[20]}.
  - Bit stream b_n = s_n[21], which gives b_{n+22} = b_n ^ b_{n+1}.
  - Symbol n = {b_n, b_{n+1}}.
- Internal 22-bit register r. Each enabled symbol shifts one bit in at r[0], so r[21] is the oldest bit.
- Predictions from r before the shift:
  - exp_hi = r[21]^r[20]
  - exp_lo = r[20]^r[19]
- Per-symbol mismatch: mis = sym_in ^ {exp_hi, exp_lo}. nerr = popcount(mis), range 0..2.
- A symbol is good when nerr == 0 and r != 0.
- SEARCH:
  - Shift sym_in[1] into r. fill_cnt increments.
  - After the 22nd symbol, go to TRACK with good_cnt = 0.
- TRACK:
  - Shift sym_in[1] into r (self-synchronising).
  - Good symbol: good_cnt++. Otherwise good_cnt = 0.
  - When good_cnt reaches LOCK_CNT, go to LOCKED with err_run = 0.
- LOCKED:
  - Shift exp_hi into r (flywheel), so channel errors are never fed back.
  - sym_cnt++ on every symbol.
  - When nerr > 0: bit_err_cnt += nerr, sym_err pulses, err_run++.
  - When nerr == 0: err_run = 0.
  - When err_run reaches LOSS_CNT, go to SEARCH with fill_cnt = 0.
- All-zero r never counts as good, so a stuck-zero input never locks.
- Counters saturate at 2^CNT_W-1. An increment that would overflow leaves the counter at max.
- clr_cnt has priority over a same-cycle increment: both counters become 0 and that symbol's errors are dropped.
- clr_cnt does not change state, r or locked.
- When sym_en is low: no state change, sym_err = 0, counters hold.

## Timing
- All outputs are registered.
- Reset (reset == 0 at a clk edge): next cycle state = SEARCH, r = 0, fill_cnt = good_cnt = err_run = 0, locked = 0, sym_err = 0, both counters = 0.
- Reset overrides sym_en and clr_cnt.
- Reset mid-lock takes effect the next cycle and returns the block to SEARCH.
- Latency: every output reflects the symbol sampled at edge k at edge k+1.
- Lock acquisition on a clean stream: locked rises the cycle after enabled symbol number 22+LOCK_CNT.
- Lock loss: locked falls the cycle after the LOSS_CNT-th consecutive errored symbol. sym_err is also high for that symbol.
- fill_cnt restarts from 0 after lock loss. Reacquisition needs another 22+LOCK_CNT clean symbols.
- There is no minimum spacing between sym_en strobes; sym_en may be high every cycle.

## Test plan
- Clean stream, generator seeded 22'h000001, sym_en every cycle -> state goes 0→1→2; locked rises the cycle after the 86th symbol; after 1000 more symbols bit_err_cnt = 0 and sym_cnt = 1000.
- While locked, invert sym_in[1] on one symbol -> one sym_err pulse; bit_err_cnt = 1; locked stays high; the following 100 symbols add no errors (no error multiplication).
- While locked, invert both bits for 8 consecutive symbols -> bit_err_cnt = 16; locked falls the cycle after the 8th; clean stream resumes; locked rises again 86 symbols later.
- sym_in held at 2'b00 for 500 symbols after reset -> state never reaches LOCKED; locked = 0; counters = 0.
- Overrides CNT_W = 4, LOSS_CNT = 16; while locked inject 9 double-bit errors -> bit_err_cnt saturates at 15; assert clr_cnt on the same cycle as an error -> bit_err_cnt = 0 next cycle and locked unchanged.
- While locked, toggle sym_en in a 1-high/3-low pattern, then pull reset low for one cycle -> checks unaffected by the gaps; the cycle after reset all outputs are 0 and state = SEARCH.
